// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to serve all multiplies from one combinational XLEN x XLEN multiplier.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                accept;
    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [2*XLEN-1:0]   step;
    logic [XLEN:0]       rs, df, sm;

    // Magnitude-domain result -> signed result, then pick the half/quotient/remainder.
    function automatic logic [XLEN-1:0] fin_result(input logic [2:0] f, input logic [2*XLEN-1:0] v,
                                                   input logic n, input logic rn);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = n  ? -v : v;
        q = n  ? -v[XLEN-1:0] : v[XLEN-1:0];
        r = rn ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
        case (f)
            3'b000:                 return p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return p[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return q;
            default:                return r;
        endcase
    endfunction

    assign in_ready  = (state_q == S_IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) && (op_a == MOST_NEG) && (op_b == '1);
        if (div_zero) special_res = funct3[1] ? op_a : '1;
        else          special_res = funct3[1] ? '0 : op_a;
    end

    // BITS_PER_CYCLE unrolled radix-2 steps; the accumulator holds {hi, lo} for both ops.
    always_comb begin
        step = acc_q;
        rs   = '0;
        df   = '0;
        sm   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (f3_q[2]) begin
                rs = {step[2*XLEN-1:XLEN], step[XLEN-1]};
                df = rs - {1'b0, opnd_q};
                if (!df[XLEN]) step = {df[XLEN-1:0], step[XLEN-2:0], 1'b1};
                else           step = {rs[XLEN-1:0], step[XLEN-2:0], 1'b0};
            end else begin
                sm   = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, opnd_q} : '0);
                step = {sm, step[XLEN-1:1]};
            end
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`endif

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d   = funct3;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = CW'(N);
                    if (funct3[2]) begin
                        opnd_d = b_mag;
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{XLEN{1'b0}}, b_mag};
                    end
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3[2]) begin
                        result_d = fin_result(funct3, fast_prod, a_neg ^ b_neg, a_neg);
                        state_d  = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = fin_result(f3_q, step, neg_q, rneg_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A kill leaves the last delivered result visible.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: two instances (1 and 4 bits per cycle) driven in lockstep,
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] MOST_NEG = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            flush = 1'b0;
    logic            in_ready1, out_valid1, busy1;
    logic            in_ready4, out_valid4, busy4;
    logic            out_ready1 = 1'b1;
    logic            out_ready4 = 1'b1;
    logic [XLEN-1:0] result1, result4;

    int n_chk = 0;
    int n_fail = 0;
    logic [XLEN-1:0] exp_q[$];

    muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .busy(busy1)
    );

    muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .busy(busy4)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_res(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = signed'(a);
        sb = signed'(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Cycle (counting the accept edge as T) in which out_valid first shows.
    function automatic int exp_lat(input logic [2:0] f, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input int bpc);
        bit fast;
        fast = f[2] && ((b == 0) || (!f[0] && a == MOST_NEG && b == '1));
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) fast = 1'b1;
`endif
        return fast ? 1 : (XLEN / bpc) + 1;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] e);
        int k, lat1, lat4;
        logic [XLEN-1:0] r1, r4, ev;
        bit s1, s4;
        exp_q.push_back(e);
        lat1 = 0; lat4 = 0; r1 = '0; r4 = '0; s1 = 0; s4 = 0;
        @(negedge clk);
        in_valid = 1'b1; funct3 = f; op_a = a; op_b = b;
        out_ready1 = 1'b1; out_ready4 = 1'b1;
        #1;
        chk({tag, "_in_ready1"}, in_ready1, 1);
        chk({tag, "_in_ready4"}, in_ready4, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
        k = 1;
        while (!(s1 && s4) && k < 80) begin
            if (!s1 && out_valid1) begin s1 = 1; lat1 = k; r1 = result1; end
            if (!s4 && out_valid4) begin s4 = 1; lat4 = k; r4 = result4; end
            if (!(s1 && s4)) begin @(posedge clk); #1; k++; end
        end
        ev = exp_q.pop_front();
        chk({tag, "_lat1"}, lat1, exp_lat(f, a, b, 1));
        chk({tag, "_res1"}, r1, ev);
        chk({tag, "_lat4"}, lat4, exp_lat(f, a, b, 4));
        chk({tag, "_res4"}, r4, ev);
        @(posedge clk); #1;
    endtask

    initial begin
        int ov;
        logic [2:0] f;
        logic [XLEN-1:0] a, b;

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_result1", result1, 0);
        chk("rst_out_valid4", out_valid4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_result4", result4, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready1", in_ready1, 1);
        chk("post_rst_in_ready4", in_ready4, 1);

        // Directed
        run_op("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_op("mulhu",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div",      3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA);
        run_op("rem",      3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE);
        run_op("divu_z",   3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF);
        run_op("remu_z",   3'd7, 32'd5,          32'd0,         32'h0000_0005);
        run_op("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("div_z",    3'd4, 32'h8000_0000,  32'd0,         32'hFFFF_FFFF);
        run_op("rem_z",    3'd6, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0);

        // Random against the reference model
        repeat (30) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = MOST_NEG; b = '1; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: begin b = 32'($urandom_range(1, 20)); end
                default: ;
            endcase
            run_op("rand", f, a, b, ref_res(f, a, b));
        end

        // Backpressure on a fast-path result
        @(negedge clk);
        out_ready1 = 1'b0; out_ready4 = 1'b0;
        in_valid = 1'b1; funct3 = 3'd5; op_a = 32'h1234; op_b = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_valid1", out_valid1, 1);
        chk("bp_valid4", out_valid4, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_res1", result1, 32'hFFFF_FFFF);
            chk("bp_hold_valid1", out_valid1, 1);
            chk("bp_hold_in_ready1", in_ready1, 0);
            chk("bp_hold_busy1", busy1, 1);
            chk("bp_hold_res4", result4, 32'hFFFF_FFFF);
            chk("bp_hold_busy4", busy4, 1);
        end
        @(negedge clk);
        out_ready1 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_valid1", out_valid1, 0);
        chk("bp_rel_in_ready1", in_ready1, 1);
        chk("bp_rel_busy1", busy1, 0);
        chk("bp_rel_valid4", out_valid4, 0);
        chk("bp_rel_in_ready4", in_ready4, 1);

        // Flush at T+10 of a divide; a request alongside flush is dropped
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0;
        #1;
        chk("flush_in_ready1", in_ready1, 0);
        chk("flush_in_ready4", in_ready4, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy1", busy1, 0);
        chk("flush_valid1", out_valid1, 0);
        chk("flush_result1", result1, 32'hFFFF_FFFF);
        chk("flush_busy4", busy4, 0);
        chk("flush_valid4", out_valid4, 0);
        ov = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid1) ov++;
        end
        chk("flush_no_valid1", ov, 0);

        // Reset in the middle of a calculation
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd4; op_a = 32'd12345; op_b = 32'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid1", out_valid1, 0);
        chk("midrst_busy1", busy1, 0);
        chk("midrst_result1", result1, 0);
        chk("midrst_busy4", busy4, 0);
        chk("midrst_result4", result4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready1", in_ready1, 1);
        run_op("after_rst", 3'd6, 32'hFFFF_FF9C, 32'd7, ref_res(3'd6, 32'hFFFF_FF9C, 32'd7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
